// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the frame-buffer SRAM arbiter
package fb_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;
  localparam int RD_CYCLES = 2;
  localparam int WR_CYCLES = 3;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, WR_C} state_t;
  typedef enum logic [1:0] {SRC_RD, SRC_FIFO, SRC_CLR} src_t;
endpackage

// File: rtl/fb_sram_arbiter_if.sv
// fb_sram_arbiter_if: requester handshakes plus SRAM pin-side signals of the arbiter
interface fb_sram_arbiter_if import fb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          rdReq;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdData;
  logic          rdValid;
  logic          rdLate;
  logic          wrReq;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrFull;
  logic          wrOverflow;
  logic          clrStart;
  logic [DW-1:0] clrValue;
  logic          clrBusy;
  logic          clrDone;
  logic [AW-1:0] aMem;
  logic [DW-1:0] dMemIn;
  logic [DW-1:0] dMemOut;
  logic          dirout;
  logic          nCsMem;
  logic          nOeMem;
  logic          nWeMem;
  modport slave (
    input  rdReq, rdAddr, wrReq, wrAddr, wrData, clrStart, clrValue, dMemIn,
    output rdData, rdValid, rdLate, wrFull, wrOverflow, clrBusy, clrDone,
           aMem, dMemOut, dirout, nCsMem, nOeMem, nWeMem
  );
  modport master (
    output rdReq, rdAddr, wrReq, wrAddr, wrData, clrStart, clrValue, dMemIn,
    input  rdData, rdValid, rdLate, wrFull, wrOverflow, clrBusy, clrDone,
           aMem, dMemOut, dirout, nCsMem, nOeMem, nWeMem
  );
endinterface

// File: rtl/wr_post_fifo.sv
// wr_post_fifo: synchronous {addr,data} write-posting FIFO; pushes while full are dropped
module wr_post_fifo #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   pop_i,
  output logic [AW-1:0]          addr_o,
  output logic [DW-1:0]          data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign {addr_o, data_o} = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wp_q] <= {addr_i, data_i};
      wp_q <= wp_q + PW'(do_push);
      rp_q <= rp_q + PW'(do_pop);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter: shares one async SRAM between display reads, posted capture writes and a clear engine
module fb_sram_arbiter import fb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  fb_sram_arbiter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q;
  src_t src_q;
  logic [AW-1:0] a_q, rd_addr_q, rd_addr_d, f_addr;
  logic [DW-1:0] d_q, rd_data_q, clr_val_q, f_data;
  logic [AW:0] clr_cnt_q;
  logic [CW-1:0] f_count;
  logic dir_q, ncs_q, noe_q, nwe_q;
  logic rd_pend_q, rd_valid_q, rd_late_q, ovf_q, clr_busy_q, clr_done_q;
  logic f_full, f_empty;
  logic decide, rd_any, rd_go, fifo_go, clr_go, clr_last;
  wr_post_fifo #(.AW(AW), .DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset),
    .push_i(bus.wrReq), .addr_i(bus.wrAddr), .data_i(bus.wrData),
    .pop_i(fifo_go), .addr_o(f_addr), .data_o(f_data),
    .full_o(f_full), .empty_o(f_empty), .count_o(f_count)
  );
  assign decide = state_q == IDLE || state_q == RD_B || state_q == WR_C;
  assign rd_any = bus.rdReq || rd_pend_q;
  assign rd_addr_d = bus.rdReq ? bus.rdAddr : rd_addr_q;
  assign rd_go = decide && rd_any;
  assign fifo_go = decide && !rd_any && !f_empty;
  // counter MSB marks that the final clear address has already been issued
  assign clr_go = decide && !rd_any && f_empty && clr_busy_q && !clr_cnt_q[AW];
  assign clr_last = state_q == WR_C && src_q == SRC_CLR && clr_cnt_q[AW];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q <= SRC_RD;
      a_q <= '0;
      d_q <= '0;
      dir_q <= 1'b1;
      ncs_q <= 1'b1;
      noe_q <= 1'b1;
      nwe_q <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      rd_late_q <= 1'b0;
      ovf_q <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      clr_val_q <= '0;
      clr_cnt_q <= '0;
    end else begin
      rd_valid_q <= state_q == RD_B;
      if (state_q == RD_B) rd_data_q <= bus.dMemIn;
      if (bus.rdReq && rd_pend_q) rd_late_q <= 1'b1;
      if (bus.wrReq && f_full) ovf_q <= 1'b1;
      rd_pend_q <= rd_go ? 1'b0 : rd_any;
      if (bus.rdReq) rd_addr_q <= bus.rdAddr;
      clr_done_q <= clr_last;
      if (clr_go) clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_last) clr_busy_q <= 1'b0;
      else if (bus.clrStart && !clr_busy_q) begin
        clr_busy_q <= 1'b1;
        clr_val_q <= bus.clrValue;
        clr_cnt_q <= '0;
      end
      if (rd_go) begin
        state_q <= RD_A;
        src_q <= SRC_RD;
        a_q <= rd_addr_d;
        d_q <= '0;
        {ncs_q, noe_q, nwe_q, dir_q} <= 4'b0011;
      end else if (fifo_go || clr_go) begin
        state_q <= WR_A;
        src_q <= fifo_go ? SRC_FIFO : SRC_CLR;
        a_q <= fifo_go ? f_addr : clr_cnt_q[AW-1:0];
        d_q <= fifo_go ? f_data : clr_val_q;
        {ncs_q, noe_q, nwe_q, dir_q} <= 4'b0110;
      end else if (decide) begin
        state_q <= IDLE;
        a_q <= '0;
        d_q <= '0;
        {ncs_q, noe_q, nwe_q, dir_q} <= 4'b1111;
      end else begin
        state_q <= state_q == RD_A ? RD_B : state_q == WR_A ? WR_B : WR_C;
        nwe_q <= state_q != WR_A;
      end
    end
  end
  assign bus.aMem = a_q;
  assign bus.dMemOut = d_q;
  assign bus.dirout = dir_q;
  assign bus.nCsMem = ncs_q;
  assign bus.nOeMem = noe_q;
  assign bus.nWeMem = nwe_q;
  assign bus.rdData = rd_data_q;
  assign bus.rdValid = rd_valid_q;
  assign bus.rdLate = rd_late_q;
  assign bus.wrFull = f_count == CW'(FIFO_DEPTH);
  assign bus.wrOverflow = ovf_q;
  assign bus.clrBusy = clr_busy_q;
  assign bus.clrDone = clr_done_q;
endmodule

// File: tb/tb_fb_sram_arbiter.sv
// tb_fb_sram_arbiter: directed checks of arbitration, FIFO posting, clear and reset against SRAM models
module tb_fb_sram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;
  fb_sram_arbiter_if #(.AW(16), .DW(8)) bus ();
  fb_sram_arbiter_if #(.AW(4), .DW(8)) cbus ();
  fb_sram_arbiter #(.AW(16), .DW(8), .FIFO_DEPTH(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  fb_sram_arbiter #(.AW(4), .DW(8), .FIFO_DEPTH(4)) u_clr (.clk(clk), .reset(reset), .bus(cbus));
  bit [7:0] mem16 [65536];
  bit [7:0] mem4 [16];
  logic ld = 1'b0, fill4 = 1'b0;
  logic [15:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  int n_chk = 0, n_err = 0, n_wr4 = 0, n_done4 = 0;
  assign bus.dMemIn = (!bus.nCsMem && !bus.nOeMem) ? mem16[bus.aMem] : 8'hEE;
  assign cbus.dMemIn = (!cbus.nCsMem && !cbus.nOeMem) ? mem4[cbus.aMem] : 8'hEE;
  always @(posedge clk) begin
    if (ld) mem16[ld_a] <= ld_d;
    else if (!bus.nCsMem && !bus.nWeMem) mem16[bus.aMem] <= bus.dMemOut;
  end
  always @(posedge clk) begin
    if (fill4) for (int i = 0; i < 16; i++) mem4[i] <= 8'hFF;
    else if (!cbus.nCsMem && !cbus.nWeMem) begin
      mem4[cbus.aMem] <= cbus.dMemOut;
      n_wr4 <= n_wr4 + 1;
    end
    if (cbus.clrDone) n_done4 <= n_done4 + 1;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] sb();
    return {bus.nCsMem, bus.nOeMem, bus.nWeMem, bus.dirout};
  endfunction
  function automatic logic [3:0] csb();
    return {cbus.nCsMem, cbus.nOeMem, cbus.nWeMem, cbus.dirout};
  endfunction
  initial begin
    logic [7:0] acc;
    {bus.rdReq, bus.rdAddr, bus.wrReq, bus.wrAddr, bus.wrData, bus.clrStart, bus.clrValue} = '0;
    {cbus.rdReq, cbus.rdAddr, cbus.wrReq, cbus.wrAddr, cbus.wrData, cbus.clrStart, cbus.clrValue} = '0;
    ld = 1'b1; ld_a = 16'h1234; ld_d = 8'hA5; fill4 = 1'b1;
    step();
    ld = 1'b0; fill4 = 1'b0;
    step();
    chk("rst_strobes", sb(), 4'b1111);
    chk("rst_amem", bus.aMem, 0);
    chk("rst_dout", bus.dMemOut, 0);
    chk("rst_rddata", bus.rdData, 0);
    chk("rst_flags", {bus.rdValid, bus.rdLate, bus.wrFull, bus.wrOverflow, bus.clrBusy, bus.clrDone}, 0);
    reset = 1'b0;
    step();
    // uncontended read
    bus.rdReq = 1'b1; bus.rdAddr = 16'h1234;
    step();
    bus.rdReq = 1'b0;
    chk("rd_a_strb", sb(), 4'b0011);
    chk("rd_a_addr", bus.aMem, 16'h1234);
    step();
    chk("rd_b_strb", sb(), 4'b0011);
    chk("rd_b_valid", bus.rdValid, 0);
    step();
    chk("rd_valid", bus.rdValid, 1);
    chk("rd_data", bus.rdData, 8'hA5);
    chk("rd_idle_strb", sb(), 4'b1111);
    step();
    chk("rd_pulse", bus.rdValid, 0);
    // single posted write
    bus.wrReq = 1'b1; bus.wrAddr = 16'h0010; bus.wrData = 8'h3C;
    step();
    bus.wrReq = 1'b0;
    chk("wr_idle_strb", sb(), 4'b1111);
    step();
    chk("wr_a_strb", sb(), 4'b0110);
    chk("wr_a_addr", bus.aMem, 16'h0010);
    chk("wr_a_data", bus.dMemOut, 8'h3C);
    step();
    chk("wr_b_strb", sb(), 4'b0100);
    step();
    chk("wr_c_strb", sb(), 4'b0110);
    step();
    chk("wr_end_strb", sb(), 4'b1111);
    chk("wr_mem", mem16[16'h0010], 8'h3C);
    // FIFO fill and overflow behind a read stream
    for (int c = 0; c <= 24; c++) begin
      bus.rdReq = (c % 2 == 0) && (c <= 8);
      bus.rdAddr = 16'(16'h2000 + c);
      bus.wrReq = (c >= 1) && (c <= 6);
      bus.wrAddr = 16'(16'h0100 + c - 1);
      bus.wrData = 8'(8'h10 + c - 1);
      if (c == 4) chk("full_c4", bus.wrFull, 0);
      if (c == 5) chk("full_c5", bus.wrFull, 1);
      if (c == 5) chk("ovf_c5", bus.wrOverflow, 0);
      if (c == 6) chk("ovf_c6", bus.wrOverflow, 1);
      if (c >= 11 && c <= 20 && (c - 11) % 3 == 0) begin
        chk("fifo_order_addr", bus.aMem, 32'(16'h0100 + (c - 11) / 3));
        chk("fifo_order_data", bus.dMemOut, 32'(8'h10 + (c - 11) / 3));
      end
      step();
    end
    {bus.rdReq, bus.wrReq} = '0;
    for (int i = 0; i < 4; i++) chk("fifo_mem", mem16[16'h0100 + i], 32'(8'h10 + i));
    chk("drop_mem4", mem16[16'h0104], 0);
    chk("drop_mem5", mem16[16'h0105], 0);
    chk("fifo_late", bus.rdLate, 0);
    chk("fifo_drained", bus.wrFull, 0);
    // simultaneous read and write from idle
    for (int c = 0; c <= 6; c++) begin
      bus.rdReq = c == 0; bus.rdAddr = 16'h1234;
      bus.wrReq = c == 0; bus.wrAddr = 16'h0020; bus.wrData = 8'h77;
      if (c == 1 || c == 2) chk("rw_rd_strb", sb(), 4'b0011);
      if (c == 3) begin
        chk("rw_valid", bus.rdValid, 1);
        chk("rw_data", bus.rdData, 8'hA5);
        chk("rw_wr_strb", sb(), 4'b0110);
        chk("rw_wr_addr", bus.aMem, 16'h0020);
      end
      if (c == 4) chk("rw_wrb_strb", sb(), 4'b0100);
      if (c == 6) chk("rw_idle_strb", sb(), 4'b1111);
      step();
    end
    chk("rw_mem", mem16[16'h0020], 8'h77);
    // late read replaces the pending address, worst-case latency behind a write
    for (int c = 0; c <= 8; c++) begin
      bus.wrReq = c == 0; bus.wrAddr = 16'h0030; bus.wrData = 8'h11;
      bus.rdReq = c == 2 || c == 3;
      bus.rdAddr = c == 2 ? 16'h0010 : 16'h1234;
      if (c == 2) chk("late_wra", sb(), 4'b0110);
      if (c == 4) chk("late_flag", bus.rdLate, 1);
      if (c == 5) begin
        chk("late_addr", bus.aMem, 16'h1234);
        chk("late_strb", sb(), 4'b0011);
      end
      if (c == 6) chk("late_valid6", bus.rdValid, 0);
      if (c == 7) begin
        chk("late_valid7", bus.rdValid, 1);
        chk("late_data", bus.rdData, 8'hA5);
      end
      step();
    end
    {bus.rdReq, bus.wrReq} = '0;
    // clear engine on the 4-bit-address instance
    for (int c = 0; c <= 55; c++) begin
      cbus.clrStart = c == 0 || c == 10;
      cbus.clrValue = c == 0 ? 8'h00 : 8'h99;
      if (c == 1) chk("clr_busy1", cbus.clrBusy, 1);
      if (c == 2) begin
        chk("clr_first_addr", cbus.aMem, 0);
        chk("clr_first_strb", csb(), 4'b0110);
      end
      if (c == 3) chk("clr_web", csb(), 4'b0100);
      if (c == 49) begin
        chk("clr_last_addr", cbus.aMem, 4'hF);
        chk("clr_busy49", cbus.clrBusy, 1);
      end
      if (c == 50) begin
        chk("clr_busy50", cbus.clrBusy, 0);
        chk("clr_done50", cbus.clrDone, 1);
      end
      if (c == 51) begin
        chk("clr_done51", cbus.clrDone, 0);
        chk("clr_idle", csb(), 4'b1111);
      end
      step();
    end
    cbus.clrStart = 1'b0;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | mem4[i];
    chk("clr_fill", acc, 0);
    chk("clr_writes", n_wr4, 16);
    chk("clr_done_cnt", n_done4, 1);
    // reset in the middle of a write with FIFO and clear work outstanding
    for (int c = 0; c <= 8; c++) begin
      bus.wrReq = c == 0 || c == 1;
      bus.wrAddr = 16'(16'h0040 + c);
      bus.wrData = 8'(8'h55 + c);
      bus.clrStart = c == 2; bus.clrValue = 8'hAB;
      reset = c == 3;
      if (c == 3) begin
        chk("mid_wrb", sb(), 4'b0100);
        chk("mid_busy", bus.clrBusy, 1);
      end
      if (c == 4) begin
        chk("mid_rst_strb", sb(), 4'b1111);
        chk("mid_rst_busy", bus.clrBusy, 0);
        chk("mid_rst_full", bus.wrFull, 0);
        chk("mid_rst_late", bus.rdLate, 0);
      end
      if (c == 6 || c == 7) chk("mid_fifo_empty", sb(), 4'b1111);
      step();
    end
    {bus.wrReq, bus.clrStart} = '0;
    chk("mid_lost_write", mem16[16'h0041], 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
